// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the RV32 data memory with its UART TX window.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int TXDATA_OFF = 0;
    localparam int STATUS_OFF = 4;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_CNT_LSB   = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } acc_size_e;

    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_RAM    = 2'd1,
        SRC_STATUS = 2'd2
    } ld_src_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic acc_size_e f3_size(input logic [2:0] f3);
        return acc_size_e'(f3[1:0]);
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Core MEM-stage to data-memory bus: request side plus registered load return and fault flags.
interface dmem_mmio_if #(
    parameter int MXLEN = 32
);
    logic             req;
    logic             we;
    logic [2:0]       funct3;
    logic [MXLEN-1:0] addr;
    logic [MXLEN-1:0] w_data;
    logic             exception;
    logic [MXLEN-1:0] r_data;
    logic             rvalid;
    logic             load_misaligned;
    logic             store_misaligned;
    logic             access_fault;

    modport master (
        output req, we, funct3, addr, w_data, exception,
        input  r_data, rvalid, load_misaligned, store_misaligned, access_fault
    );

    modport slave (
        input  req, we, funct3, addr, w_data, exception,
        output r_data, rvalid, load_misaligned, store_misaligned, access_fault
    );
endinterface

// File: rtl/dmem_tx_fifo.sv
// Synchronous UART TX FIFO; a push while full is dropped and latches a sticky overflow bit.
module dmem_tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clr_overflow,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic             push_ok;
    logic             pop_ok;

    // Both qualifiers look at the pre-edge occupancy, so a pop cannot make room for a same-edge push.
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge CLK) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (push && full)
                overflow_reg <= 1'b1;
            else if (clr_overflow)
                overflow_reg <= 1'b0;
        end
    end

    assign head     = empty ? '0 : fifo_mem[rd_ptr_reg];
    assign overflow = overflow_reg;
    assign count    = count_reg;

endmodule

// File: rtl/dmem_mmio.sv
// RV32 data memory with a UART TX window (TXDATA push / STATUS read) and a 1-cycle load path.
// Optional DMEM_TX_IRQ_EN adds tx_irq, raised when a pop drains the TX FIFO.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int               MXLEN       = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter int               FIFO_DEPTH  = 8,
    parameter logic [MXLEN-1:0] UART_BASE   = 'h0001_0000
) (
    input  logic       CLK,
    input  logic       RST_N,
    dmem_mmio_if.slave bus,
    output logic       uart_tx_valid,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_ready
`ifdef DMEM_TX_IRQ_EN
    ,
    output logic       tx_irq
`endif
);

    localparam int               IDX_W       = $clog2(DEPTH_WORDS);
    localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [MXLEN-1:0] RAM_BYTES   = MXLEN'(DEPTH_WORDS * 4);
    localparam logic [MXLEN-1:0] TXDATA_ADDR = UART_BASE + MXLEN'(TXDATA_OFF);
    localparam logic [MXLEN-1:0] STATUS_ADDR = UART_BASE + MXLEN'(STATUS_OFF);

    acc_size_e        size;
    logic             f3_ok;
    logic             misalign;
    logic [1:0]       off;
    logic [IDX_W-1:0] word_idx;
    logic             hit_ram;
    logic             hit_txdata;
    logic             hit_status;
    logic             mapped;
    logic             acc_ok;
    logic             ld_ok;
    logic             st_ok;

    assign size       = f3_size(bus.funct3);
    assign f3_ok      = f3_legal(bus.we, bus.funct3);
    assign off        = bus.addr[1:0];
    assign word_idx   = bus.addr[2 +: IDX_W];
    assign misalign   = f3_ok && (((size == SZ_HALF) && off[0]) ||
                                  ((size == SZ_WORD) && (off != 2'b00)));
    assign hit_ram    = (bus.addr < RAM_BYTES);
    assign hit_txdata = (bus.addr == TXDATA_ADDR);
    assign hit_status = (bus.addr == STATUS_ADDR);
    assign mapped     = hit_ram || hit_txdata || hit_status;

    assign bus.load_misaligned  = bus.req && !bus.we && misalign;
    assign bus.store_misaligned = bus.req && bus.we && misalign;
    assign bus.access_fault     = bus.req && (!f3_ok || !mapped);

    // Only a clean, non-trapping access may touch RAM, the FIFO or the overflow bit.
    assign acc_ok = bus.req && !bus.exception && f3_ok && !misalign && mapped;
    assign ld_ok  = acc_ok && !bus.we;
    assign st_ok  = acc_ok && bus.we;

    logic [3:0]  byte_en;
    logic [31:0] st_lanes;

    always_comb begin
        byte_en  = 4'b0000;
        st_lanes = bus.w_data[31:0];
        case (size)
            SZ_BYTE: begin
                byte_en  = 4'b0001 << off;
                st_lanes = {4{bus.w_data[7:0]}};
            end
            SZ_HALF: begin
                byte_en  = off[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{bus.w_data[15:0]}};
            end
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    logic [31:0] ram_q;

    // One byte-wide array per lane keeps byte-enable writes inferable as block RAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] lane_q_reg;

        always_ff @(posedge CLK) begin
            if (st_ok && hit_ram && byte_en[gi])
                lane_mem[word_idx] <= st_lanes[gi*8 +: 8];
            if (ld_ok && hit_ram)
                lane_q_reg <= lane_mem[word_idx];
        end

        assign ram_q[gi*8 +: 8] = lane_q_reg;
    end

    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_overflow;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;

    assign fifo_push = st_ok && hit_txdata;
    assign fifo_pop  = uart_tx_valid && uart_tx_ready;

    dmem_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .push         (fifo_push),
        .push_data    (bus.w_data[7:0]),
        .pop          (fifo_pop),
        .clr_overflow (st_ok && hit_status),
        .head         (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow     (fifo_overflow),
        .count        (fifo_count)
    );

    assign uart_tx_valid = !fifo_empty;
    assign uart_tx_data  = fifo_head;

    logic [31:0] status_word;

    always_comb begin
        status_word                              = '0;
        status_word[STAT_FULL_BIT]               = fifo_full;
        status_word[STAT_EMPTY_BIT]              = fifo_empty;
        status_word[STAT_OVF_BIT]                = fifo_overflow;
        status_word[STAT_CNT_LSB +: CNT_W]       = fifo_count;
    end

    logic        rvalid_reg;
    ld_src_e     src_reg;
    ld_src_e     src_next;
    logic [2:0]  f3_reg;
    logic [1:0]  off_reg;
    logic [31:0] status_q_reg;

    always_comb begin
        src_next = SRC_ZERO;
        if (ld_ok && hit_ram)
            src_next = SRC_RAM;
        else if (ld_ok && hit_status)
            src_next = SRC_STATUS;
    end

    // Every load, including faulting or trapped ones, returns a pulse; those return zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid_reg   <= 1'b0;
            src_reg      <= SRC_ZERO;
            f3_reg       <= '0;
            off_reg      <= '0;
            status_q_reg <= '0;
        end else begin
            rvalid_reg <= bus.req && !bus.we;
            if (bus.req && !bus.we) begin
                src_reg <= src_next;
                f3_reg  <= bus.funct3;
                off_reg <= off;
                if (ld_ok && hit_status)
                    status_q_reg <= status_word;
            end
        end
    end

    logic [31:0]      ld_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [MXLEN-1:0] ld_data;

    always_comb begin
        ld_word = '0;
        if (src_reg == SRC_RAM)
            ld_word = ram_q;
        else if (src_reg == SRC_STATUS)
            ld_word = status_q_reg;
        ld_byte = ld_word[{off_reg, 3'b000} +: 8];
        ld_half = off_reg[1] ? ld_word[31:16] : ld_word[15:0];
        case (f3_reg)
            F3_B:    ld_data = MXLEN'(signed'(ld_byte));
            F3_H:    ld_data = MXLEN'(signed'(ld_half));
            F3_W:    ld_data = MXLEN'(signed'(ld_word));
            F3_BU:   ld_data = MXLEN'(ld_byte);
            F3_HU:   ld_data = MXLEN'(ld_half);
            default: ld_data = '0;
        endcase
    end

    assign bus.r_data = ld_data;
    assign bus.rvalid = rvalid_reg;

`ifdef DMEM_TX_IRQ_EN
    logic tx_irq_reg;
    logic tx_drain;

    assign tx_drain = fifo_pop && (fifo_count == CNT_W'(1)) && !(fifo_push && !fifo_full);

    // Setting has priority over the STATUS-read acknowledge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            tx_irq_reg <= 1'b0;
        else if (tx_drain)
            tx_irq_reg <= 1'b1;
        else if (ld_ok && hit_status)
            tx_irq_reg <= 1'b0;
    end

    assign tx_irq = tx_irq_reg;
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus a randomized run against a byte-level model.
module tb_dmem_mmio;

    localparam int          RAM_BYTES = 4096;
    localparam int          FD        = 8;
    localparam logic [31:0] UB        = 32'h0001_0000;

    logic       CLK;
    logic       RST_N;
    logic       uart_tx_valid;
    logic [7:0] uart_tx_data;
    logic       uart_tx_ready;
    logic       tx_irq;

    dmem_mmio_if #(.MXLEN(32)) bus ();

    dmem_mmio #(
        .MXLEN       (32),
        .DEPTH_WORDS (1024),
        .FIFO_DEPTH  (FD),
        .UART_BASE   (UB)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .bus           (bus),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready)
`ifdef DMEM_TX_IRQ_EN
        ,
        .tx_irq        (tx_irq)
`endif
    );

`ifndef DMEM_TX_IRQ_EN
    assign tx_irq = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] ram_m [RAM_BYTES];
    logic [7:0] fifo_q [$];
    bit         ovf_m;
    bit         irq_m;

    logic        exp_lmis, exp_smis, exp_fault, exp_rvalid, exp_txv;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_txd;
    logic        obs_lmis, obs_smis, obs_fault, obs_rvalid, obs_txv, obs_irq;
    logic [31:0] obs_rdata;
    logic [7:0]  obs_txd;

    task automatic model_reset();
        fifo_q.delete();
        ovf_m = 0;
        irq_m = 0;
    endtask

    task automatic model(input bit req, input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit exc, input bit rdy);
        bit legal, mis, mapped, ok, pop, push;
        int nb, pre;
        logic [31:0] v;
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nb     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis    = legal && ((a % nb) != 0);
        mapped = (a < RAM_BYTES) || (a == UB) || (a == UB + 4);
        ok     = req && !exc && legal && !mis && mapped;
        exp_lmis   = req && !we && mis;
        exp_smis   = req && we && mis;
        exp_fault  = req && (!legal || !mapped);
        exp_rvalid = req && !we;
        v = 0;
        if (ok && !we) begin
            if (a < RAM_BYTES) begin
                for (int i = 0; i < nb; i++) v |= 32'(ram_m[a + i]) << (8 * i);
            end else if (a == UB + 4) begin
                v = {16'd0, 8'(fifo_q.size()), 5'd0, ovf_m, fifo_q.size() == 0, fifo_q.size() == FD};
                if (nb < 4) v &= (32'd1 << (8 * nb)) - 1;
            end
            if (f3 < 3'd4 && nb < 4 && v[8 * nb - 1]) v |= ~((32'd1 << (8 * nb)) - 1);
        end
        exp_rdata = v;
        pre  = fifo_q.size();
        pop  = (pre > 0) && rdy;
        push = ok && we && (a == UB);
        if (pop) void'(fifo_q.pop_front());
        if (push) begin
            if (pre == FD) ovf_m = 1;
            else fifo_q.push_back(wd[7:0]);
        end
        if (ok && we && a == UB + 4) ovf_m = 0;
        if (pop && pre == 1 && !(push && pre < FD)) irq_m = 1;
        else if (ok && !we && a == UB + 4) irq_m = 0;
        if (ok && we && a < RAM_BYTES)
            for (int i = 0; i < nb; i++) ram_m[a + i] = wd[8 * i +: 8];
        exp_txv = fifo_q.size() > 0;
        exp_txd = exp_txv ? fifo_q[0] : 8'h00;
    endtask

    // One bus cycle starting at a falling edge; captures flags before the edge and results after it.
    task automatic step(input bit req, input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit exc, input bit rdy);
        bus.req = req; bus.we = we; bus.funct3 = f3; bus.addr = a;
        bus.w_data = wd; bus.exception = exc; uart_tx_ready = rdy;
        #1;
        obs_lmis  = bus.load_misaligned;
        obs_smis  = bus.store_misaligned;
        obs_fault = bus.access_fault;
        model(req, we, f3, a, wd, exc, rdy);
        @(posedge CLK);
        @(negedge CLK);
        obs_rvalid = bus.rvalid;
        obs_rdata  = bus.r_data;
        obs_txv    = uart_tx_valid;
        obs_txd    = uart_tx_data;
        obs_irq    = tx_irq;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.req = 0; bus.we = 0; bus.funct3 = 0; bus.addr = 0; bus.w_data = 0; bus.exception = 0;
        uart_tx_ready = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({bus.rvalid, bus.r_data, uart_tx_valid, uart_tx_data} !== 42'd0)
            $display("FAIL reset_outputs: rvalid=%0b r_data=%h tx_valid=%0b tx_data=%h, required all zero",
                     bus.rvalid, bus.r_data, uart_tx_valid, uart_tx_data);
        else n_pass++;
        n_checks++;
        if (tx_irq !== 1'b0) $display("FAIL reset_irq: got %0b want 0", tx_irq);
        else n_pass++;
        RST_N = 1'b1;
    endtask

    task automatic test_ram_loads();
        logic [2:0]  lf [6];
        logic [31:0] la [6];
        logic [31:0] le [6];
        lf = '{3'd0, 3'd4, 3'd1, 3'd2, 3'd5, 3'd0};
        la = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10};
        le = '{32'hFFFFFFA1, 32'h000000A1, 32'hFFFFA1B2, 32'hA1B2C3D4, 32'h0000C3D4, 32'hFFFFFFD4};
        step(1, 1, 3'd2, 32'h10, 32'hA1B2C3D4, 0, 0);
        n_checks++;
        if (obs_rvalid !== 1'b0) $display("FAIL store_no_rvalid: got %0b want 0", obs_rvalid);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, lf[i], la[i], 32'h0, 0, 0);
            n_checks++;
            if (obs_rvalid !== 1'b1 || obs_rdata !== le[i])
                $display("FAIL load_ext[%0d]: rvalid=%0b r_data=%h want rvalid=1 r_data=%h", i, obs_rvalid, obs_rdata, le[i]);
            else n_pass++;
        end
        step(1, 1, 3'd2, 32'h20, 32'h13579BDF, 0, 0);
        step(1, 1, 3'd0, 32'h11, 32'hFFFFFF55, 0, 0);
        step(1, 0, 3'd2, 32'h10, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'hA1B255D4) $display("FAIL sb_lane: got %h want a1b255d4", obs_rdata);
        else n_pass++;
        step(1, 1, 3'd1, 32'h12, 32'h12348001, 0, 0);
        step(1, 0, 3'd2, 32'h10, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h800155D4) $display("FAIL sh_lane: got %h want 800155d4", obs_rdata);
        else n_pass++;
        step(1, 0, 3'd1, 32'h12, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'hFFFF8001) $display("FAIL lh_sign: got %h want ffff8001", obs_rdata);
        else n_pass++;
        step(0, 0, 3'd0, 32'h0, 32'h0, 0, 0);
        n_checks++;
        if (obs_rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %0b want 0", obs_rvalid);
        else n_pass++;
    endtask

    task automatic test_faults();
        step(1, 0, 3'd2, 32'h12, 32'h0, 0, 0);
        n_checks++;
        if ({obs_lmis, obs_smis, obs_fault} !== 3'b100)
            $display("FAIL lw_misaligned_flags: lmis/smis/fault=%b want 100", {obs_lmis, obs_smis, obs_fault});
        else n_pass++;
        n_checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'h0)
            $display("FAIL lw_misaligned_data: rvalid=%0b r_data=%h want 1/0", obs_rvalid, obs_rdata);
        else n_pass++;
        step(1, 1, 3'd1, 32'h21, 32'h0000BEEF, 0, 0);
        n_checks++;
        if ({obs_lmis, obs_smis, obs_fault} !== 3'b010)
            $display("FAIL sh_misaligned_flags: lmis/smis/fault=%b want 010", {obs_lmis, obs_smis, obs_fault});
        else n_pass++;
        step(1, 1, 3'd4, 32'h20, 32'hDEADBEEF, 0, 0);
        n_checks++;
        if (obs_fault !== 1'b1) $display("FAIL store_bad_f3: fault=%0b want 1", obs_fault);
        else n_pass++;
        step(1, 0, 3'd2, 32'h20, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h13579BDF) $display("FAIL ram_unchanged: got %h want 13579bdf", obs_rdata);
        else n_pass++;
        step(1, 0, 3'd3, 32'h20, 32'h0, 0, 0);
        n_checks++;
        if (obs_fault !== 1'b1 || obs_rdata !== 32'h0)
            $display("FAIL load_bad_f3: fault=%0b r_data=%h want 1/0", obs_fault, obs_rdata);
        else n_pass++;
        step(1, 0, 3'd2, 32'h1000, 32'h0, 0, 0);
        n_checks++;
        if (obs_fault !== 1'b1 || obs_rvalid !== 1'b1 || obs_rdata !== 32'h0)
            $display("FAIL unmapped_load: fault=%0b rvalid=%0b r_data=%h want 1/1/0", obs_fault, obs_rvalid, obs_rdata);
        else n_pass++;
        step(1, 0, 3'd0, UB + 1, 32'h0, 0, 0);
        n_checks++;
        if (obs_fault !== 1'b1) $display("FAIL uart_hole: fault=%0b want 1", obs_fault);
        else n_pass++;
        step(1, 0, 3'd2, 32'h20, 32'h0, 1, 0);
        n_checks++;
        if (obs_fault !== 1'b0 || obs_rvalid !== 1'b1 || obs_rdata !== 32'h0)
            $display("FAIL exc_load: fault=%0b rvalid=%0b r_data=%h want 0/1/0", obs_fault, obs_rvalid, obs_rdata);
        else n_pass++;
    endtask

    task automatic test_fifo_overflow();
        for (int i = 0; i < 9; i++) step(1, 1, 3'd0, UB, 32'(8'h41 + i), 0, 0);
        step(1, 0, 3'd2, UB + 4, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00000805) $display("FAIL status_full_ovf: got %h want 00000805", obs_rdata);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_txv !== 1'b1 || obs_txd !== 8'(8'h41 + i))
                $display("FAIL drain_order[%0d]: valid=%0b data=%h want 1/%h", i, obs_txv, obs_txd, 8'(8'h41 + i));
            else n_pass++;
            step(0, 0, 3'd0, 32'h0, 32'h0, 0, 1);
        end
        n_checks++;
        if (obs_txv !== 1'b0) $display("FAIL drained_valid: got %0b want 0", obs_txv);
        else n_pass++;
        step(1, 0, 3'd2, UB + 4, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00000006) $display("FAIL status_empty_ovf: got %h want 00000006", obs_rdata);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        step(1, 1, 3'd2, UB + 4, 32'h0, 0, 0);
        step(1, 0, 3'd2, UB + 4, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00000002) $display("FAIL ovf_clear_1: got %h want 00000002", obs_rdata);
        else n_pass++;
        for (int i = 0; i < 8; i++) step(1, 1, 3'd0, UB, 32'(8'h60 + i), 0, 0);
        step(1, 1, 3'd0, UB, 32'h7F, 0, 1);
        step(1, 0, 3'd2, UB + 4, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00000704) $display("FAIL full_push_pop: got %h want 00000704", obs_rdata);
        else n_pass++;
        step(1, 1, 3'd0, UB + 4, 32'h0, 0, 0);
        step(1, 0, 3'd2, UB + 4, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00000700) $display("FAIL ovf_clear_2: got %h want 00000700", obs_rdata);
        else n_pass++;
        repeat (7) step(0, 0, 3'd0, 32'h0, 32'h0, 0, 1);
        n_checks++;
        if (obs_txv !== 1'b0) $display("FAIL drain_after_full: valid=%0b want 0", obs_txv);
        else n_pass++;
    endtask

    task automatic test_exception_and_reset();
        step(1, 1, 3'd0, UB, 32'h31, 0, 0);
        step(1, 1, 3'd0, UB, 32'h32, 0, 0);
        step(1, 1, 3'd0, UB, 32'h33, 1, 0);
        step(1, 1, 3'd2, 32'h10, 32'hFFFF0000, 1, 0);
        step(1, 0, 3'd2, UB + 4, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00000200) $display("FAIL exc_no_push: got %h want 00000200", obs_rdata);
        else n_pass++;
        step(1, 0, 3'd2, 32'h10, 32'h0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h800155D4) $display("FAIL exc_no_write: got %h want 800155d4", obs_rdata);
        else n_pass++;
        bus.req = 1; bus.we = 0; bus.funct3 = 3'd2; bus.addr = 32'h10; bus.exception = 0;
        #2 RST_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({bus.rvalid, bus.r_data, uart_tx_valid, uart_tx_data} !== 42'd0)
            $display("FAIL reset_mid_load: rvalid=%0b r_data=%h tx_valid=%0b tx_data=%h want zeros",
                     bus.rvalid, bus.r_data, uart_tx_valid, uart_tx_data);
        else n_pass++;
        bus.req = 0;
        RST_N = 1'b1;
        model_reset();
        step(1, 0, 3'd2, 32'h10, 32'h0, 0, 0);
        n_checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'h800155D4)
            $display("FAIL ram_kept_reset: rvalid=%0b r_data=%h want 1/800155d4", obs_rvalid, obs_rdata);
        else n_pass++;
    endtask

    task automatic test_irq();
`ifdef DMEM_TX_IRQ_EN
        step(1, 1, 3'd0, UB, 32'h5A, 0, 0);
        n_checks++;
        if (obs_irq !== 1'b0) $display("FAIL irq_idle: got %0b want 0", obs_irq);
        else n_pass++;
        step(0, 0, 3'd0, 32'h0, 32'h0, 0, 1);
        n_checks++;
        if (obs_irq !== 1'b1) $display("FAIL irq_set: got %0b want 1", obs_irq);
        else n_pass++;
        step(1, 0, 3'd2, UB + 4, 32'h0, 0, 0);
        n_checks++;
        if (obs_irq !== 1'b0) $display("FAIL irq_clear: got %0b want 0", obs_irq);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        int kind;
        for (int w = 0; w < 16; w++) step(1, 1, 3'd2, 32'(w * 4), $urandom, 0, 0);
        step(1, 1, 3'd2, 32'd4088, $urandom, 0, 0);
        step(1, 1, 3'd2, 32'd4092, $urandom, 0, 0);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 2)      a = 32'($urandom_range(0, 63));
            else if (kind == 3) a = 32'($urandom_range(4088, 4103));
            else if (kind == 4) a = UB + 32'($urandom_range(0, 9));
            else                a = $urandom;
            step($urandom_range(0, 9) < 8, $urandom_range(0, 1), 3'($urandom_range(0, 7)), a, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1));
            n_checks++;
            if ({obs_lmis, obs_smis, obs_fault, obs_rvalid, obs_txv, obs_txd} !==
                {exp_lmis, exp_smis, exp_fault, exp_rvalid, exp_txv, exp_txd})
                $display("FAIL rand_ctl[%0d]: lmis,smis,fault,rvalid,txv,txd=%b,%b,%b,%b,%b,%h want %b,%b,%b,%b,%b,%h",
                         n, obs_lmis, obs_smis, obs_fault, obs_rvalid, obs_txv, obs_txd,
                         exp_lmis, exp_smis, exp_fault, exp_rvalid, exp_txv, exp_txd);
            else n_pass++;
            if (exp_rvalid) begin
                n_checks++;
                if (obs_rdata !== exp_rdata)
                    $display("FAIL rand_rdata[%0d]: got %h want %h (addr %h)", n, obs_rdata, exp_rdata, a);
                else n_pass++;
            end
`ifdef DMEM_TX_IRQ_EN
            n_checks++;
            if (obs_irq !== irq_m) $display("FAIL rand_irq[%0d]: got %0b want %0b", n, obs_irq, irq_m);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_ram_loads();
        test_faults();
        test_fifo_overflow();
        test_full_push_pop();
        test_exception_and_reset();
        test_irq();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
